// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, flag indices and writeback entry type
// shared by the ALU writeback stage and its FIFO.
package alu_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam logic [3:0] OP_OUT  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'ha;
  localparam logic [3:0] OP_ROR  = 4'hb;
  localparam logic [3:0] OP_INC  = 4'hc;
  localparam logic [3:0] OP_DEC  = 4'hd;
  localparam logic [3:0] OP_SLT  = 4'he;
  localparam logic [3:0] OP_SLTU = 4'hf;

  localparam int FLAG_EQ = 3;
  localparam int FLAG_NE = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic                 we;
  } wb_entry_t;

  // Only ADD and SUB produce a meaningful overflow flag.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - generic DEPTH-entry valid/ready FIFO of writeback entries;
// registered status only, no empty bypass.
module wb_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_entry,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_entry
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_entry = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage: skid FIFO, condition flags, sticky
// overflow; ALU_WB_OVF_TRAP_EN suppresses overflowed writes and pulses ovf_trap.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_ovf,
  input  logic [3:0]        in_cond,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_we,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [3:0]        flags,
  output logic              ovf_sticky,
  input  logic              ovf_clr,
  output logic              ovf_trap
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
  } stage_entry_t;

  stage_entry_t in_entry, out_entry;
  logic         accept, ovf_event;
  logic [3:0]   flags_q, flags_d;
  logic         ovf_sticky_q, ovf_sticky_d;

  assign accept    = in_valid & in_ready;
  assign ovf_event = accept & is_arith(in_opcode) & in_ovf;

  always_comb begin
    in_entry.addr = in_rd;
    in_entry.data = in_data;
    // r0 is hardwired, so a write to it is never presented.
`ifdef ALU_WB_OVF_TRAP_EN
    in_entry.we   = in_we & (in_rd != '0) & ~ovf_event;
`else
    in_entry.we   = in_we & (in_rd != '0);
`endif
  end

  always_comb begin
    flags_d      = flags_q;
    ovf_sticky_d = ovf_sticky_q;
    if (accept && (in_opcode == OP_SUB)) begin
      flags_d = in_cond;
    end
    if (ovf_event) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= 4'b0000;
      ovf_sticky_q <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

`ifdef ALU_WB_OVF_TRAP_EN
  logic ovf_trap_q, ovf_trap_d;

  always_comb begin
    ovf_trap_d = ovf_event;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_trap_q <= 1'b0;
    end else begin
      ovf_trap_q <= ovf_trap_d;
    end
  end

  assign ovf_trap = ovf_trap_q;
`else
  assign ovf_trap = 1'b0;
`endif

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (stage_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .out_valid (wb_valid),
    .out_ready (wb_ready),
    .out_entry (out_entry)
  );

  assign wb_addr    = out_entry.addr;
  assign wb_data    = out_entry.data;
  assign wb_we      = out_entry.we;
  assign flags      = flags_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule
